// File: rtl/shifter_planar_packer.sv
// shifter_planar_packer: serial pixel colour indices in, ST bitplane words out.
// Collects 16 pixels per group into up to four plane shift registers, the
// first pixel landing in bit 15. Each group's plane words are then offered
// on a valid/ready port in bus order, plane 0 first.
// Optional feature macro: STE_HSCROLL_EN adds pix_skip, which pre-fills the
// first group of each display-enable period with PAD_BIT positions.
module shifter_planar_packer #(
  parameter logic PAD_BIT = 1'b0
) (
  input  logic        clk32,
  input  logic        nReset,
  input  logic        pixClkEn,
  input  logic        DE,
  input  logic [1:0]  rez,
  input  logic [3:0]  color_index,
`ifdef STE_HSCROLL_EN
  input  logic [3:0]  pix_skip,
`endif
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [1:0]  plane,
  output logic        overflow,
  input  logic        ovf_clr
);

  logic        de_q;
  logic [3:0]  cnt;
  logic        fresh;
  logic [1:0]  grp_rez;
  logic [15:0] sr [4];
  logic [15:0] hold [4];
  logic [1:0]  hold_last;

  logic        de_rise, de_fall, sample, flush, complete;
  logic        eff_fresh, accept, last_acc, can_load, load, drop;
  logic [3:0]  start_cnt, eff_cnt;
  logic [1:0]  act_rez, grp_last;
  logic [4:0]  flush_sh;
  logic [15:0] pad_mask;
  logic [15:0] sr_base [4];
  logic [15:0] sr_shift [4];
  logic [15:0] grp_word [4];

`ifdef STE_HSCROLL_EN
  assign start_cnt = pix_skip;
`else
  assign start_cnt = 4'd0;
`endif

  // Group bookkeeping: edge detect, effective counter and the completed group's words
  always_comb begin
    de_rise   = DE & ~de_q;
    de_fall   = ~DE & de_q;
    sample    = pixClkEn & DE;
    eff_cnt   = de_rise ? start_cnt : cnt;
    eff_fresh = de_rise | fresh;
    act_rez   = (sample & eff_fresh) ? rez : grp_rez;
    flush     = de_fall & (cnt != 4'd0);
    complete  = (sample & (eff_cnt == 4'd15)) | flush;
    // An early flush holds cnt pixels in the low bits; left-align them and pad below.
    flush_sh  = 5'd16 - {1'b0, cnt};
    pad_mask  = PAD_BIT ? (16'hFFFF >> cnt) : 16'h0000;
    case (act_rez)
      2'd0:    grp_last = 2'd3;
      2'd1:    grp_last = 2'd1;
      default: grp_last = 2'd0;
    endcase
    for (int p = 0; p < 4; p++) begin
      sr_base[p]  = de_rise ? {16{PAD_BIT}} : sr[p];
      sr_shift[p] = {sr_base[p][14:0], color_index[p]};
      grp_word[p] = flush ? ((sr[p] << flush_sh) | pad_mask) : sr_shift[p];
    end
    accept   = word_valid & word_ready;
    last_acc = accept & (plane == hold_last);
    can_load = ~word_valid | last_acc;
    load     = complete & can_load;
    drop     = complete & ~can_load;
  end

  // Pixel capture: shift registers, pixel counter and per-group resolution latch
  always_ff @(posedge clk32) begin
    if (!nReset) begin
      de_q    <= 1'b0;
      cnt     <= 4'd0;
      fresh   <= 1'b1;
      grp_rez <= 2'd0;
      for (int p = 0; p < 4; p++) sr[p] <= 16'h0000;
    end else begin
      de_q <= DE;
      if (sample) begin
        if (eff_fresh) grp_rez <= rez;
        if (eff_cnt == 4'd15) begin
          cnt   <= 4'd0;
          fresh <= 1'b1;
          for (int p = 0; p < 4; p++) sr[p] <= 16'h0000;
        end else begin
          cnt   <= eff_cnt + 4'd1;
          fresh <= 1'b0;
          for (int p = 0; p < 4; p++) sr[p] <= sr_shift[p];
        end
      end else if (flush) begin
        cnt   <= 4'd0;
        fresh <= 1'b1;
        for (int p = 0; p < 4; p++) sr[p] <= 16'h0000;
      end else if (de_rise) begin
        cnt   <= start_cnt;
        fresh <= 1'b1;
        for (int p = 0; p < 4; p++) sr[p] <= {16{PAD_BIT}};
      end
    end
  end

  // Output side: hold buffer, plane sequencing over the handshake, sticky overflow
  always_ff @(posedge clk32) begin
    if (!nReset) begin
      word_out   <= 16'h0000;
      word_valid <= 1'b0;
      plane      <= 2'd0;
      overflow   <= 1'b0;
      hold_last  <= 2'd0;
      for (int p = 0; p < 4; p++) hold[p] <= 16'h0000;
    end else begin
      if (load) begin
        for (int p = 0; p < 4; p++) hold[p] <= grp_word[p];
        hold_last  <= grp_last;
        word_out   <= grp_word[0];
        word_valid <= 1'b1;
        plane      <= 2'd0;
      end else if (last_acc) begin
        word_valid <= 1'b0;
        plane      <= 2'd0;
      end else if (accept) begin
        plane    <= plane + 2'd1;
        word_out <= hold[plane + 2'd1];
      end
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shifter_planar_packer.sv
// Bench for shifter_planar_packer: directed pixel streams, a queue-based
// reference model checked every cycle, and literal expectations per test.
module tb_shifter_planar_packer;

  localparam logic PAD = 1'b0;

  logic        clk32 = 1'b0;
  logic        nReset, pixClkEn, DE, word_ready, ovf_clr;
  logic [1:0]  rez;
  logic [3:0]  color_index;
  logic [15:0] word_out;
  logic        word_valid, overflow;
  logic [1:0]  plane;
`ifdef STE_HSCROLL_EN
  logic [3:0]  pix_skip;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  pl;
    logic [15:0] w;
  } ent_t;

  ent_t       mq[$];
  ent_t       alog[$];
  logic [3:0] m_pix[$];
  int         m_off;
  logic [1:0] m_rez;
  logic       m_de, m_ovf;
  logic       s_valid;
  ent_t       s_ent;

  shifter_planar_packer #(.PAD_BIT(PAD)) dut (
    .clk32(clk32), .nReset(nReset), .pixClkEn(pixClkEn), .DE(DE), .rez(rez),
    .color_index(color_index),
`ifdef STE_HSCROLL_EN
    .pix_skip(pix_skip),
`endif
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .plane(plane), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word for plane p: position i of the group is bit 15-i; skipped and unfilled positions are PAD.
  function automatic logic [15:0] mk_word(int p);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) begin
      if (i < m_off || (i - m_off) >= m_pix.size()) w[15-i] = PAD;
      else w[15-i] = m_pix[i-m_off][p];
    end
    return w;
  endfunction

  // Reference model step on each edge, then compare the DUT against it.
  always @(posedge clk32) begin
    logic done, drop;
    int nw, skip_val;
    if (nReset && s_valid && word_ready) alog.push_back(s_ent);
    if (!nReset) begin
      mq.delete(); m_pix.delete();
      m_off = 0; m_rez = 2'd0; m_de = 1'b0; m_ovf = 1'b0;
    end else begin
      if (mq.size() > 0 && word_ready) void'(mq.pop_front());
      done = 1'b0; drop = 1'b0;
`ifdef STE_HSCROLL_EN
      skip_val = int'(pix_skip);
`else
      skip_val = 0;
`endif
      if (DE && !m_de) begin
        m_pix.delete();
        m_off = skip_val;
      end
      if (DE && pixClkEn) begin
        if (m_pix.size() == 0) m_rez = rez;
        m_pix.push_back(color_index);
        if (m_off + m_pix.size() == 16) done = 1'b1;
      end else if (!DE && m_de && (m_off + m_pix.size()) != 0) done = 1'b1;
      if (done) begin
        nw = (m_rez == 2'd0) ? 4 : (m_rez == 2'd1) ? 2 : 1;
        if (mq.size() == 0) begin
          for (int p = 0; p < nw; p++) mq.push_back('{pl: 2'(p), w: mk_word(p)});
        end else drop = 1'b1;
        m_pix.delete();
        m_off = 0;
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_de = DE;
    end
    #1;
    chk("valid", 32'(word_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("word", 32'(word_out), 32'(mq[0].w));
      chk("plane", 32'(plane), 32'(mq[0].pl));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    s_valid = word_valid;
    s_ent   = '{pl: plane, w: word_out};
  end

  task automatic cyc(input logic de, input logic en, input logic [3:0] idx, input logic rdy);
    @(negedge clk32);
    DE = de; pixClkEn = en; color_index = idx; word_ready = rdy;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk32);
    DE = 1'b0; pixClkEn = 1'b0; word_ready = 1'b1;
    while (n < 40) begin
      @(posedge clk32); #2;
      if (!word_valid) break;
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL drain timeout: word_valid still %b expected 0", word_valid);
    end
  endtask

  task automatic chk_log(input string name, input int i, input logic [1:0] pl, input logic [15:0] w);
    if (i < alog.size()) begin
      chk({name, " plane"}, 32'(alog[i].pl), 32'(pl));
      chk({name, " word"}, 32'(alog[i].w), 32'(w));
    end else chk({name, " missing"}, 32'(alog.size()), 32'(i + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0;
    nReset = 1'b0; DE = 1'b0; pixClkEn = 1'b0; rez = 2'd0; color_index = 4'd0;
    word_ready = 1'b0; ovf_clr = 1'b0;
`ifdef STE_HSCROLL_EN
    pix_skip = 4'd0;
`endif
    repeat (3) @(negedge clk32);
    nReset = 1'b1;
    @(posedge clk32); #2;
    chk("reset word_out", 32'(word_out), 32'h0);
    chk("reset valid", 32'(word_valid), 32'h0);
    chk("reset plane", 32'(plane), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);

    // 1: low rez, idx = 0..15
    alog.delete(); rez = 2'd0;
    for (int n = 0; n < 16; n++) cyc(1'b1, 1'b1, 4'(n), 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 4'd0, 1'b1);
    drain();
    chk("t1 count", 32'(alog.size()), 32'd4);
    chk_log("t1 w0", 0, 2'd0, 16'h5555);
    chk_log("t1 w1", 1, 2'd1, 16'h3333);
    chk_log("t1 w2", 2, 2'd2, 16'h0F0F);
    chk_log("t1 w3", 3, 2'd3, 16'h00FF);

    // 2: mid rez, gapped pixel enable, consumer stalls
    alog.delete(); rez = 2'd1;
    for (int k = 0; k < 32; k++) cyc(1'b1, (k % 2) == 0, 4'd3, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 4'd0, 1'b0);
      @(posedge clk32); #2;
      chk("t2 hold valid", 32'(word_valid), 32'h1);
      chk("t2 hold word", 32'(word_out), 32'hFFFF);
      chk("t2 hold plane", 32'(plane), 32'h0);
    end
    drain();
    chk("t2 count", 32'(alog.size()), 32'd2);
    chk_log("t2 w0", 0, 2'd0, 16'hFFFF);
    chk_log("t2 w1", 1, 2'd1, 16'hFFFF);
    chk("t2 valid after", 32'(word_valid), 32'h0);

    // 3: high rez, early flush after 5 pixels
    alog.delete(); rez = 2'd2;
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 4'd1, 1'b0);
    @(posedge clk32); #2;
    chk("t3 no word before fall", 32'(word_valid), 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    @(posedge clk32); #2;
    chk("t3 valid after fall", 32'(word_valid), 32'h1);
    chk("t3 flush word", 32'(word_out), 32'hF800);
    drain();
    chk_log("t3 w0", 0, 2'd0, 16'hF800);

    // 4: two full groups while stalled -> second dropped
    alog.delete(); rez = 2'd0;
    for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1, 4'(k % 16), 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    @(posedge clk32); #2;
    chk("t4 overflow set", 32'(overflow), 32'h1);
    @(negedge clk32); ovf_clr = 1'b1;
    @(negedge clk32); ovf_clr = 1'b0;
    @(posedge clk32); #2;
    chk("t4 overflow cleared", 32'(overflow), 32'h0);
    drain();
    chk("t4 count", 32'(alog.size()), 32'd4);
    chk_log("t4 w0", 0, 2'd0, 16'h5555);
    chk_log("t4 w1", 1, 2'd1, 16'h3333);
    chk_log("t4 w2", 2, 2'd2, 16'h0F0F);
    chk_log("t4 w3", 3, 2'd3, 16'h00FF);

    // 5: next group completes on the cycle the last word is accepted
    alog.delete(); rez = 2'd1;
    for (int k = 0; k < 32; k++)
      cyc(1'b1, 1'b1, (k < 16) ? 4'd1 : 4'(k - 16), (k == 30) || (k == 31));
    @(posedge clk32); #2;
    chk("t5 valid kept", 32'(word_valid), 32'h1);
    chk("t5 plane restart", 32'(plane), 32'h0);
    chk("t5 new data", 32'(word_out), 32'h5555);
    chk("t5 no overflow", 32'(overflow), 32'h0);
    drain();
    chk("t5 count", 32'(alog.size()), 32'd4);
    chk_log("t5 a0", 0, 2'd0, 16'hFFFF);
    chk_log("t5 a1", 1, 2'd1, 16'h0000);
    chk_log("t5 b0", 2, 2'd0, 16'h5555);
    chk_log("t5 b1", 3, 2'd1, 16'h3333);

`ifdef STE_HSCROLL_EN
    // 6: hard-scroll skip of 4 on the first group
    alog.delete(); rez = 2'd2; pix_skip = 4'd4;
    for (int k = 0; k < 28; k++) cyc(1'b1, 1'b1, (k < 12) ? 4'd1 : 4'(k - 12), 1'b1);
    drain();
    pix_skip = 4'd0;
    chk("t6 count", 32'(alog.size()), 32'd2);
    chk_log("t6 w0", 0, 2'd0, 16'h0FFF);
    chk_log("t6 w1", 1, 2'd0, 16'h5555);
`endif

    // 7: reset mid-handshake and mid-group discards everything
    alog.delete(); rez = 2'd0;
    for (int k = 0; k < 21; k++) cyc(1'b1, 1'b1, 4'd7, 1'b0);
    @(negedge clk32);
    nReset = 1'b0; DE = 1'b0; pixClkEn = 1'b0;
    @(negedge clk32);
    nReset = 1'b1;
    @(posedge clk32); #2;
    chk("t7 valid after reset", 32'(word_valid), 32'h0);
    chk("t7 plane after reset", 32'(plane), 32'h0);
    for (int n = 0; n < 16; n++) cyc(1'b1, 1'b1, 4'(15 - n), 1'b1);
    drain();
    chk("t7 count", 32'(alog.size()), 32'd4);
    chk_log("t7 w0", 0, 2'd0, 16'hAAAA);
    chk_log("t7 w1", 1, 2'd1, 16'hCCCC);
    chk_log("t7 w2", 2, 2'd2, 16'hF0F0);
    chk_log("t7 w3", 3, 2'd3, 16'hFF00);

    repeat (3) @(negedge clk32);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
